// File: rtl/regwb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regwb_arbiter
// Description : Two-requester register-file writeback arbiter with alternating
//               priority, one-cycle registered write port and r0 write drop.
// Revision    : 1.0
// ============================================================================
module regwb_arbiter #(
    parameter logic PRIO_RESET = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        a_valid,
    input  logic [3:0]  a_addr,
    input  logic [15:0] a_data,
    output logic        a_ready,
    input  logic        b_valid,
    input  logic [3:0]  b_addr,
    input  logic [15:0] b_data,
    output logic        b_ready,
    output logic        we3,
    output logic [3:0]  wa3,
    output logic [15:0] wd3,
    output logic        grant_b
);

    logic        r_prio;
    logic        r_we3;
    logic [3:0]  r_wa3;
    logic [15:0] r_wd3;
    logic        r_grant_b;

    logic        w_open;
    logic        w_a_ready;
    logic        w_b_ready;

    // A side loses a tie only when priority points at B, and vice versa.
    assign w_open    = rst_n & ~stall;
    assign w_a_ready = w_open & a_valid & (~b_valid | ~r_prio);
    assign w_b_ready = w_open & b_valid & (~a_valid |  r_prio);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_prio    <= PRIO_RESET;
            r_we3     <= 1'b0;
            r_wa3     <= 4'd0;
            r_wd3     <= 16'd0;
            r_grant_b <= 1'b0;
        end else begin
            r_we3 <= 1'b0;
            if (w_a_ready) begin
                // r0 is hardwired to zero: the request is consumed but not written.
                r_we3     <= (a_addr != 4'd0);
                r_wa3     <= a_addr;
                r_wd3     <= a_data;
                r_grant_b <= 1'b0;
                r_prio    <= 1'b1;
            end else if (w_b_ready) begin
                r_we3     <= (b_addr != 4'd0);
                r_wa3     <= b_addr;
                r_wd3     <= b_data;
                r_grant_b <= 1'b1;
                r_prio    <= 1'b0;
            end
        end
    end

    assign a_ready = w_a_ready;
    assign b_ready = w_b_ready;
    assign we3     = r_we3;
    assign wa3     = r_wa3;
    assign wd3     = r_wd3;
    assign grant_b = r_grant_b;

endmodule
`default_nettype wire
